// File: rtl/processor_ctrl_if.sv
// Controller <-> instruction memory / datapath bundle; master is the sequencer side.
// Purely combinational wiring, no flow control: the datapath is strobed by single-cycle enables.
interface processor_ctrl_if #(
    parameter int PC_WIDTH = 5
);
    logic [7:0]          instruction_code;
    logic                acc_zero;
    logic [PC_WIDTH-1:0] prog_cnt;
    logic                rstn_inter;
    logic                acumulator_ce;
    logic                reg_file_ce;
    logic [2:0]          alu_op;
    logic [4:0]          reg_addr;
    logic                halted;

    modport master (
        input  instruction_code, acc_zero,
        output prog_cnt, rstn_inter, acumulator_ce, reg_file_ce, alu_op, reg_addr, halted
    );

    modport slave (
        output instruction_code, acc_zero,
        input  prog_cnt, rstn_inter, acumulator_ce, reg_file_ce, alu_op, reg_addr, halted
    );
endinterface

// File: rtl/processor_ctrl.sv
// FETCH/DECODE/EXECUTE sequencer for the 8-bit accumulator CPU; 3 cycles per instruction, enables registered.
// No backpressure: the datapath must accept every enable pulse; HALT freezes the PC until external reset.
module processor_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int PC_WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rstn_ext,
    processor_ctrl_if.master bus
);
    typedef enum logic [2:0] {RST_WAIT, FETCH, DECODE, EXECUTE, HALT} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t              state, state_next;
    logic [3:0]          rst_cnt, rst_cnt_next;
    logic [7:0]          ir, ir_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic                rstn_q, rstn_next;
    logic                acc_ce_q, acc_ce_next;
    logic                rf_ce_q, rf_ce_next;
    logic                halted_q, halted_next;
    logic [2:0]          alu_op_q, alu_op_next;
    logic [4:0]          reg_addr_q, reg_addr_next;
    logic [PC_WIDTH-1:0] operand;

    assign operand = PC_WIDTH'(ir[4:0]);

    always_ff @(posedge clk) begin
        if (!rstn_ext) begin
            state      <= RST_WAIT;
            rst_cnt    <= '0;
            ir         <= '0;
            pc         <= '0;
            rstn_q     <= 1'b0;
            acc_ce_q   <= 1'b0;
            rf_ce_q    <= 1'b0;
            halted_q   <= 1'b0;
            alu_op_q   <= '0;
            reg_addr_q <= '0;
        end else begin
            state      <= state_next;
            rst_cnt    <= rst_cnt_next;
            ir         <= ir_next;
            pc         <= pc_next;
            rstn_q     <= rstn_next;
            acc_ce_q   <= acc_ce_next;
            rf_ce_q    <= rf_ce_next;
            halted_q   <= halted_next;
            alu_op_q   <= alu_op_next;
            reg_addr_q <= reg_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        rst_cnt_next  = rst_cnt;
        ir_next       = ir;
        pc_next       = pc;
        rstn_next     = rstn_q;
        acc_ce_next   = 1'b0;
        rf_ce_next    = 1'b0;
        halted_next   = halted_q;
        alu_op_next   = alu_op_q;
        reg_addr_next = reg_addr_q;

        unique case (state)
            RST_WAIT: begin
                rst_cnt_next = rst_cnt + 4'd1;
                if (rst_cnt == 4'(RST_CYCLES - 1)) begin
                    rstn_next  = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                ir_next    = bus.instruction_code;
                state_next = DECODE;
            end
            DECODE: begin
                // Enables are launched here so they are high for exactly the EXECUTE cycle.
                alu_op_next   = ir[7:5];
                reg_addr_next = ir[4:0];
                acc_ce_next   = (ir[7:5] == OP_LOAD) || (ir[7:5] == OP_ADD) || (ir[7:5] == OP_SUB);
                rf_ce_next    = (ir[7:5] == OP_STORE);
                state_next    = EXECUTE;
            end
            EXECUTE: begin
                state_next = FETCH;
                case (ir[7:5])
                    OP_JMP:  pc_next = operand;
                    OP_JZ:   pc_next = bus.acc_zero ? operand : pc + PC_WIDTH'(1);
                    OP_HALT: begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                    end
                    default: pc_next = pc + PC_WIDTH'(1);
                endcase
            end
            HALT: begin
                halted_next = 1'b1;
            end
            default: state_next = RST_WAIT;
        endcase
    end

    assign bus.prog_cnt      = pc;
    assign bus.rstn_inter    = rstn_q;
    assign bus.acumulator_ce = acc_ce_q;
    assign bus.reg_file_ce   = rf_ce_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.reg_addr      = reg_addr_q;
    assign bus.halted        = halted_q;
endmodule
